// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM encoding and default width for the multiply/divide unit
package mdu_pkg;
    localparam int MDU_DATA_W = 32;
    localparam logic [2:0] MDU_NOP   = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_MULTU = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_DIVU  = 3'b100;
    localparam logic [2:0] MDU_MTHI  = 3'b101;
    localparam logic [2:0] MDU_MTLO  = 3'b110;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: restoring unsigned divider, one quotient bit per enabled cycle
module mdu_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quo,
    output logic [W-1:0] rem
);
    logic [W-1:0] dvs;
    logic [W:0]   trial;
    assign trial = {rem, quo[W-1]} - {1'b0, dvs};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo <= '0;
            rem <= '0;
            dvs <= '0;
        end else if (load) begin
            quo <= dividend;
            rem <= '0;
            dvs <= divisor;
        end else if (en) begin
            rem <= trial[W] ? {rem[W-2:0], quo[W-1]} : trial[W-1:0];
            quo <= {quo[W-2:0], ~trial[W]};
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/DIV with HI/LO; define MDU_FAST_MUL_EN for a single-cycle multiply
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        Ctrl_mdu,
    input  logic [DATA_W-1:0] input1,
    input  logic [DATA_W-1:0] input2,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    state_t state, next_state;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   mcand, a_raw, a_mag, b_mag, quo, rem, div_hi, div_lo;
    logic [2*DATA_W-1:0] prod, mul_res;
    logic [DATA_W:0]     sum;
    logic neg_p, neg_r, dz, op_div, sgn, is_mul, is_mul_it, is_div, go, last, ld, step, wr;

    assign is_mul = Ctrl_mdu == MDU_MULT || Ctrl_mdu == MDU_MULTU;
    assign is_div = Ctrl_mdu == MDU_DIV || Ctrl_mdu == MDU_DIVU;
    assign sgn    = Ctrl_mdu == MDU_MULT || Ctrl_mdu == MDU_DIV;
    assign go     = start && state == S_IDLE;
    assign last   = count == CNT_W'(DATA_W - 1);
    assign a_mag  = (sgn && input1[DATA_W-1]) ? -input1 : input1;
    assign b_mag  = (sgn && input2[DATA_W-1]) ? -input2 : input2;
`ifdef MDU_FAST_MUL_EN
    logic signed [2*DATA_W-1:0] fast_s;
    logic [2*DATA_W-1:0] fast_u;
    assign fast_s    = $signed(input1) * $signed(input2);
    assign fast_u    = {{DATA_W{1'b0}}, input1} * {{DATA_W{1'b0}}, input2};
    assign is_mul_it = 1'b0;
`else
    assign is_mul_it = is_mul;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state == S_IDLE ? (go && is_mul_it ? S_MUL : go && is_div ? S_DIV : S_IDLE)
                   : state == S_FIX  ? S_IDLE
                   : last            ? S_FIX : state;
    end

    always_comb begin
        ld   = go && (is_mul_it || is_div);
        step = state == S_MUL || state == S_DIV;
        wr   = state == S_FIX;
    end

    // Shift-add on {upper, multiplier}: carry lands in the top bit before the right shift
    assign sum     = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, prod[0] ? mcand : {DATA_W{1'b0}}};
    assign mul_res = neg_p ? -prod : prod;
    assign div_lo  = dz ? '1 : neg_p ? -quo : quo;
    assign div_hi  = dz ? a_raw : neg_r ? -rem : rem;

    mdu_divider #(.W(DATA_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ld),
        .en       (state == S_DIV),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo      (quo),
        .rem      (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            count  <= '0;
            mcand  <= '0;
            prod   <= '0;
            a_raw  <= '0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            op_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            busy  <= next_state != S_IDLE;
            count <= ld ? '0 : step ? count + 1'b1 : count;
            if (ld) begin
                mcand  <= a_mag;
                prod   <= {{DATA_W{1'b0}}, b_mag};
                a_raw  <= input1;
                neg_p  <= sgn && (input1[DATA_W-1] ^ input2[DATA_W-1]);
                neg_r  <= sgn && input1[DATA_W-1];
                dz     <= is_div && input2 == '0;
                op_div <= is_div;
            end else if (state == S_MUL) begin
                prod <= {sum, prod[DATA_W-1:1]};
            end
            if (wr) {hi, lo} <= op_div ? {div_hi, div_lo} : mul_res;
            else if (go && Ctrl_mdu == MDU_MTHI) hi <= input1;
            else if (go && Ctrl_mdu == MDU_MTLO) lo <= input1;
`ifdef MDU_FAST_MUL_EN
            else if (go && is_mul) {hi, lo} <= sgn ? fast_s : fast_u;
`endif
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
    import mdu_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  ctrl = MDU_NOP;
    logic [31:0] in1 = '0, in2 = '0;
    logic        busy;
    logic [31:0] hi, lo;
    logic [63:0] hl_m = '0;
    int compared = 0, mismatched = 0;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Ctrl_mdu(ctrl),
        .input1(in1), .input2(in2), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] cur);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] r = cur;
        if (op == MDU_MULT) r = 64'(sa * sb);
        else if (op == MDU_MULTU) r = {32'h0, a} * {32'h0, b};
        else if ((op == MDU_DIV || op == MDU_DIVU) && b == 0) r = {a, 32'hFFFF_FFFF};
        else if (op == MDU_DIV) r = {32'(sa % sb), 32'(sa / sb)};
        else if (op == MDU_DIVU) r = {a % b, a / b};
        else if (op == MDU_MTHI) r[63:32] = a;
        else if (op == MDU_MTLO) r[31:0] = a;
        return r;
    endfunction

    function automatic int exp_cycles(input logic [2:0] op);
`ifdef MDU_FAST_MUL_EN
        return (op == MDU_DIV || op == MDU_DIVU) ? 33 : 0;
`else
        return (op >= MDU_MULT && op <= MDU_DIVU) ? 33 : 0;
`endif
    endfunction

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc = 0;
        logic [63:0] held = hl_m;
        @(negedge clk);
        start = 1'b1; ctrl = op; in1 = a; in2 = b;
        @(negedge clk);
        start = 1'b0; ctrl = MDU_NOP; in1 = $urandom; in2 = $urandom;
        while (busy && cyc < 100) begin
            if (cyc == 16) chk({tag, "_hold"}, {hi, lo}, held);
            @(negedge clk);
            cyc++;
        end
        hl_m = model(op, a, b, hl_m);
        chk({tag, "_cycles"}, 64'(cyc), 64'(exp_cycles(op)));
        chk({tag, "_hi"}, 64'(hi), 64'(hl_m[63:32]));
        chk({tag, "_lo"}, 64'(lo), 64'(hl_m[31:0]));
    endtask

    initial begin
        start = 1'b1; ctrl = MDU_MTHI; in1 = 32'hDEAD_BEEF; in2 = 32'h1;
        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'h0);
        chk("rst_lo", 64'(lo), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        start = 1'b0; ctrl = MDU_NOP;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hi", 64'(hi), 64'h0);
        chk("idle_busy", 64'(busy), 64'h0);

        run("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run("mult_neg", MDU_MULT, -32'sd7, 32'sd3);
        chk("mult_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run("div_neg", MDU_DIV, -32'sd7, 32'sd2);
        chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run("divu_zero", MDU_DIVU, 32'd100, 32'd0);
        run("div_zero_neg", MDU_DIV, 32'hFFFF_FF00, 32'd0);
        run("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);
        run("nop", MDU_NOP, 32'h1111, 32'h2222);
        run("undef", 3'b111, 32'h3333, 32'h4444);

        @(negedge clk);
        start = 1'b1; ctrl = MDU_MTHI; in1 = 32'h1234;
        @(negedge clk);
        chk("mthi_busy", 64'(busy), 64'h0);
        ctrl = MDU_MTLO; in1 = 32'h5678;
        @(negedge clk);
        chk("mtlo_busy", 64'(busy), 64'h0);
        start = 1'b0; ctrl = MDU_NOP;
        hl_m = {32'h1234, 32'h5678};
        chk("mthi_mtlo", {hi, lo}, hl_m);

        start = 1'b1; ctrl = MDU_DIV; in1 = 32'd1000; in2 = 32'd7;
        @(negedge clk);
        start = 1'b0; ctrl = MDU_NOP;
        repeat (5) @(negedge clk);
        start = 1'b1; ctrl = MDU_MTLO; in1 = 32'hDEAD;
        @(negedge clk);
        start = 1'b0; ctrl = MDU_NOP;
        chk("mtlo_busy_lo", 64'(lo), 64'h5678);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        hl_m = model(MDU_DIV, 32'd1000, 32'd7, hl_m);
        chk("div_mtlo_ignored", {hi, lo}, hl_m);

        for (int i = 0; i < 24; i++) begin
            logic [2:0] op = 3'($urandom_range(0, 7));
            logic [31:0] a = $urandom, b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom >> $urandom_range(0, 31);
            run($sformatf("rnd%0d", i), op, a, b);
        end

        @(negedge clk);
        start = 1'b1; ctrl = MDU_MULT; in1 = 32'h7FFF_0001; in2 = 32'h0000_0013;
        @(negedge clk);
        start = 1'b0; ctrl = MDU_NOP;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_hi", 64'(hi), 64'h0);
        chk("abort_lo", 64'(lo), 64'h0);
        chk("abort_busy", 64'(busy), 64'h0);
        hl_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run("divu_9_4", MDU_DIVU, 32'd9, 32'd4);
        chk("divu_9_4_const", {hi, lo}, 64'h0000_0001_0000_0002);
        run("multu_max_again", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
